cbd2_sampler: RTL

- Upstream neighbour of the NTT stage.
- Consumes the PRF byte stream as 32-bit words and applies the Kyber centered binomial distribution with eta=2.
- Assembles one complete 256-coefficient polynomial of 3-bit signed coefficients in [-2,+2], the exact input format of the NTT.
- Presents the polynomial in parallel to the NTT and holds it until the NTT accepts it.

---
 rtl/kyber_pkg.sv | 19 +
 rtl/cbd2_sampler_if.sv | 42 ++++
 rtl/cbd2_nibble.sv | 18 +
 rtl/cbd2_sampler.sv | 82 ++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and types for the sampler and NTT front-end blocks.
package kyber_pkg;

  localparam int KYBER_N   = 256;
  localparam int KYBER_Q   = 3329;
  localparam int KYBER_ETA = 2;

  // Each CBD sample consumes 2*eta bits of PRF output.
  localparam int NIB_W = 2 * KYBER_ETA;

  typedef logic signed [2:0] cbd_coef_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } cbd_state_t;

endpackage

// File: rtl/cbd2_sampler_if.sv
// Handshake bundle between the PRF source, the CBD sampler and the NTT.
interface cbd2_sampler_if
  import kyber_pkg::*;
#(
  parameter int N_COEF = KYBER_N,
  parameter int IN_W   = 32
) ();

  logic             start;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  cbd_coef_t        poly_out [0:N_COEF-1];
  logic             poly_valid;
  logic             poly_ready;
  logic             busy;

  // Environment side: PRF source and NTT consumer.
  modport master (
    output start,
    output in_data,
    output in_valid,
    output poly_ready,
    input  in_ready,
    input  poly_out,
    input  poly_valid,
    input  busy
  );

  // Sampler side.
  modport slave (
    input  start,
    input  in_data,
    input  in_valid,
    input  poly_ready,
    output in_ready,
    output poly_out,
    output poly_valid,
    output busy
  );

endinterface

// File: rtl/cbd2_nibble.sv
// Centered binomial sample (eta=2) of one 4-bit nibble: popcount(n[1:0]) - popcount(n[3:2]).
module cbd2_nibble
  import kyber_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output cbd_coef_t        coef
);

  logic [1:0] pos_cnt;
  logic [1:0] neg_cnt;

  assign pos_cnt = {1'b0, nib[0]} + {1'b0, nib[1]};
  assign neg_cnt = {1'b0, nib[2]} + {1'b0, nib[3]};

  // Modulo-8 subtraction yields the two's-complement code directly (-2..+2).
  assign coef = cbd_coef_t'({1'b0, pos_cnt} - {1'b0, neg_cnt});

endmodule

// File: rtl/cbd2_sampler.sv
// Kyber CBD(eta=2) sampler: turns 32 PRF words into one 256-coefficient
// polynomial and holds it in parallel for the NTT until it is accepted.
module cbd2_sampler
  import kyber_pkg::*;
#(
  parameter int N_COEF = KYBER_N,
  parameter int IN_W   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  cbd2_sampler_if.slave bus
);

  localparam int LANES  = IN_W / NIB_W;
  localparam int WORDS  = N_COEF * NIB_W / IN_W;
  localparam int CNT_W  = $clog2(WORDS);
  localparam int LANE_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  cbd_state_t       state;
  logic [CNT_W-1:0] word_cnt;
  cbd_coef_t        poly_buf  [0:N_COEF-1];
  cbd_coef_t        lane_coef [LANES];
  logic             accept;

  // One sampler lane per nibble of the input word.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cbd2_nibble u_nibble (
      .nib  (bus.in_data[NIB_W*g +: NIB_W]),
      .coef (lane_coef[g])
    );
  end

  assign accept         = (state == FILL) && bus.in_valid;
  assign bus.in_ready   = (state == FILL);
  assign bus.poly_valid = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.poly_out   = poly_buf;

  // Control FSM: IDLE waits for start, FILL counts accepted words, DONE holds for the NTT.
  // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= FILL;
            word_cnt <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            if (word_cnt == LAST_WORD) begin
              state    <= DONE;
              word_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.poly_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Coefficient buffer: each accepted word fills its own slice of LANES entries.
  // NOTE: this register array is deliberately reset so the NTT never sees stale data after a reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_COEF; i++) poly_buf[i] <= '0;
    end else if (accept) begin
      for (int l = 0; l < LANES; l++) poly_buf[{word_cnt, LANE_W'(l)}] <= lane_coef[l];
    end
  end

endmodule
